// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner: default synchroniser depth,
// default debounce length and the debounce counter width helper.
package input_cond_pkg;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;

   // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so
   // DEBOUNCE_CYCLES of 1 or 2 still yields a legal vector.
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// One conditioner channel: synchroniser chain, stability counter, clean level
// register and rise pulse. Fall pulse output exists only when FALL_PULSE_EN is defined.
module debounce_ch
   import input_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_clean,
   output logic o_rise
`ifdef FALL_PULSE_EN
   ,
   output logic o_fall
`endif
);

   localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_clean;
   logic                   r_rise;
   logic                   w_sync;
   logic                   w_differs;
   logic                   w_accept;

   assign w_sync    = r_sync[SYNC_STAGES-1];
   assign w_differs = w_sync ^ r_clean;
   assign w_accept  = w_differs && (r_cnt == CNT_MAX);

   // Plain flop chain: nothing may sit between stages or metastability
   // settling time is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_clean <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_rise <= w_accept & w_sync;
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_clean <= w_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_clean = r_clean;
   assign o_rise  = r_rise;

`ifdef FALL_PULSE_EN
   logic r_fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fall <= 1'b0;
      end else begin
         r_fall <= w_accept & ~w_sync;
      end
   end

   assign o_fall = r_fall;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Input conditioner top: N_CH independent synchronise/debounce/edge channels.
// Define FALL_PULSE_EN to add the fall_pulse output.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int N_CH            = 3,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] clean_out,
   output logic [N_CH-1:0] rise_pulse
`ifdef FALL_PULSE_EN
   ,
   output logic [N_CH-1:0] fall_pulse
`endif
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .i_raw   (raw_in[g]),
         .o_clean (clean_out[g]),
         .o_rise  (rise_pulse[g])
`ifdef FALL_PULSE_EN
         ,
         .o_fall  (fall_pulse[g])
`endif
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random input streams,
// all compared against a window-based debounce model.
module tb_input_conditioner;
   import input_cond_pkg::*;

   localparam int N_CH = 3;
   localparam int S    = DEF_SYNC_STAGES;
   localparam int D    = DEF_DEBOUNCE_CYCLES;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_CH-1:0] raw_in = '0;
   logic [N_CH-1:0] clean_out;
   logic [N_CH-1:0] rise_pulse;
`ifdef FALL_PULSE_EN
   logic [N_CH-1:0] fall_pulse;
`endif

   int n_total = 0;
   int n_bad   = 0;

   // model state
   bit              pipe_q [N_CH][$];
   bit              eval_q [N_CH][$];
   logic [N_CH-1:0] mdl_clean = '0;
   logic [N_CH-1:0] mdl_rise  = '0;
   logic [N_CH-1:0] mdl_fall  = '0;

   input_conditioner #(
      .N_CH            (N_CH),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in),
      .clean_out  (clean_out),
      .rise_pulse (rise_pulse)
`ifdef FALL_PULSE_EN
      ,
      .fall_pulse (fall_pulse)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // A value is accepted once the last D synchronised samples seen since the
   // previous acceptance all differ from the clean level.
   task automatic model_edge();
      bit sync_v;
      bit ok;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (rst) begin
            pipe_q[ch].delete();
            for (int k = 0; k < S; k++) pipe_q[ch].push_back(1'b0);
            eval_q[ch].delete();
            mdl_clean[ch] = 1'b0;
            mdl_rise[ch]  = 1'b0;
            mdl_fall[ch]  = 1'b0;
         end else begin
            sync_v = pipe_q[ch].pop_front();
            pipe_q[ch].push_back(raw_in[ch]);
            mdl_rise[ch] = 1'b0;
            mdl_fall[ch] = 1'b0;
            eval_q[ch].push_back(sync_v);
            if (eval_q[ch].size() > D) void'(eval_q[ch].pop_front());
            ok = (eval_q[ch].size() >= D);
            for (int k = 0; k < eval_q[ch].size(); k++)
               if (eval_q[ch][k] == mdl_clean[ch]) ok = 1'b0;
            if (ok) begin
               mdl_clean[ch] = ~mdl_clean[ch];
               mdl_rise[ch]  = mdl_clean[ch];
               mdl_fall[ch]  = ~mdl_clean[ch];
               eval_q[ch].delete();
            end
         end
      end
   endtask

   // One clock edge: update the model from the inputs held across the edge,
   // then compare every output slightly after the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      n_total++;
      if (clean_out !== mdl_clean) begin
         n_bad++;
         $display("FAIL model_clean t=%0t: got %b expected %b", $time, clean_out, mdl_clean);
      end
      n_total++;
      if (rise_pulse !== mdl_rise) begin
         n_bad++;
         $display("FAIL model_rise t=%0t: got %b expected %b", $time, rise_pulse, mdl_rise);
      end
`ifdef FALL_PULSE_EN
      n_total++;
      if (fall_pulse !== mdl_fall) begin
         n_bad++;
         $display("FAIL model_fall t=%0t: got %b expected %b", $time, fall_pulse, mdl_fall);
      end
`endif
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      raw_in = 3'b111;
      rst    = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         n_total++;
         if (clean_out !== 3'b000 || rise_pulse !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_outputs: got clean=%b rise=%b expected 000/000", clean_out, rise_pulse);
         end
      end
      raw_in = '0;
      apply_reset(S + 1);
   endtask

   task automatic test_clean_rise();
      raw_in[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_total++;
         if (clean_out[0] !== (k >= S + D) || rise_pulse[0] !== (k == S + D)) begin
            n_bad++;
            $display("FAIL clean_rise edge %0d: got clean=%b rise=%b expected clean=%b rise=%b",
                     k, clean_out[0], rise_pulse[0], k >= S + D, k == S + D);
         end
      end
      raw_in = '0;
      apply_reset(1);
   endtask

   task automatic test_glitch();
      int pulses;
      raw_in[1] = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         if (k == D) raw_in[1] = 1'b0;
         step();
         n_total++;
         if (clean_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_reject edge %0d: got clean=%b rise=%b expected 0/0",
                     k, clean_out[1], rise_pulse[1]);
         end
      end
      pulses    = 0;
      raw_in[1] = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (k == D + 1) raw_in[1] = 1'b0;
         step();
         if (rise_pulse[1] === 1'b1) pulses++;
      end
      n_total++;
      if (pulses != 1) begin
         n_bad++;
         $display("FAIL glitch_accept_pulses: got %0d expected 1", pulses);
      end
   endtask

   task automatic test_bounce();
      int pulses;
      int pulse_edge;
      apply_reset(1);
      for (int k = 0; k < 4; k++) begin
         raw_in[2] = (k % 2 == 0);
         step();
      end
      raw_in[2]  = 1'b1;
      pulses     = 0;
      pulse_edge = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (rise_pulse[2] === 1'b1) begin
            pulses++;
            pulse_edge = k;
         end
      end
      n_total++;
      if (pulses != 1 || pulse_edge != S + D) begin
         n_bad++;
         $display("FAIL bounce: got pulses=%0d at edge %0d expected 1 at edge %0d",
                  pulses, pulse_edge, S + D);
      end
      raw_in = '0;
      apply_reset(1);
   endtask

   task automatic test_mid_reset();
      raw_in[0] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         rst = (k == 4);
         step();
         n_total++;
         if (clean_out[0] !== 1'b0 || rise_pulse[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_pre edge %0d: got clean=%b rise=%b expected 0/0",
                     k, clean_out[0], rise_pulse[0]);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_total++;
         if (clean_out[0] !== (k >= S + D) || rise_pulse[0] !== (k == S + D)) begin
            n_bad++;
            $display("FAIL mid_reset_post edge %0d: got clean=%b rise=%b expected clean=%b rise=%b",
                     k, clean_out[0], rise_pulse[0], k >= S + D, k == S + D);
         end
      end
      raw_in = '0;
      apply_reset(1);
   endtask

   task automatic test_multi_channel();
      raw_in = 3'b111;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_total++;
         if (rise_pulse !== ((k == S + D) ? 3'b111 : 3'b000)) begin
            n_bad++;
            $display("FAIL multi_rise edge %0d: got %b expected %b",
                     k, rise_pulse, (k == S + D) ? 3'b111 : 3'b000);
         end
      end
      raw_in = 3'b000;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_total++;
         if (clean_out !== ((k >= S + D) ? 3'b000 : 3'b111)) begin
            n_bad++;
            $display("FAIL multi_fall_clean edge %0d: got %b expected %b",
                     k, clean_out, (k >= S + D) ? 3'b000 : 3'b111);
         end
`ifdef FALL_PULSE_EN
         n_total++;
         if (fall_pulse !== ((k == S + D) ? 3'b111 : 3'b000)) begin
            n_bad++;
            $display("FAIL multi_fall_pulse edge %0d: got %b expected %b",
                     k, fall_pulse, (k == S + D) ? 3'b111 : 3'b000);
         end
`endif
      end
   endtask

   task automatic test_random();
      int hold [N_CH];
      for (int ch = 0; ch < N_CH; ch++) hold[ch] = 0;
      for (int n = 0; n < 1500; n++) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            if (hold[ch] == 0) begin
               raw_in[ch] = 1'($urandom_range(0, 1));
               hold[ch]   = $urandom_range(1, 2 * D);
            end
            hold[ch]--;
         end
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int ch = 0; ch < N_CH; ch++)
         for (int k = 0; k < S; k++) pipe_q[ch].push_back(1'b0);
      #1;
      test_reset();
      test_clean_rise();
      test_glitch();
      test_bounce();
      test_mid_reset();
      test_multi_channel();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
